// File: rtl/l1d_wb_pkg.sv
// rtl/l1d_wb_pkg.sv - shared types and constants for the L1D write-buffer drain
package l1d_wb_pkg;

    localparam int WB_PADDR_W    = 56;
    localparam int WB_LINE_W     = 512;
    localparam int OFFSET_W      = $clog2(WB_LINE_W / 8);
    localparam int LINE_ADDR_W   = WB_PADDR_W - OFFSET_W;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef struct packed {
        logic [LINE_ADDR_W-1:0] line_addr;
        logic [WB_LINE_W-1:0]   data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } drain_state_e;

endpackage

// File: rtl/l1d_wb_drain_if.sv
// rtl/l1d_wb_drain_if.sv - line write request / ack bus between drain engine and memory
interface l1d_wb_mem_if #(
    parameter int PADDR_W = 56,
    parameter int LINE_W  = 512
);
    logic               req_vld;
    logic               req_rdy;
    logic [PADDR_W-1:0] req_addr;
    logic [LINE_W-1:0]  req_data;
    logic               resp_vld;
    logic               resp_err;

    modport master (
        output req_vld, req_addr, req_data,
        input  req_rdy, resp_vld, resp_err
    );

    modport slave (
        input  req_vld, req_addr, req_data,
        output req_rdy, resp_vld, resp_err
    );
endinterface

// File: rtl/l1d_wb_cam.sv
// rtl/l1d_wb_cam.sv - combinational line-address match over all buffer entries
module l1d_wb_cam
    import l1d_wb_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  wb_entry_t              entries_i [DEPTH],
    input  logic [DEPTH-1:0]       vld_i,
    input  logic [LINE_ADDR_W-1:0] line_addr_i,
    output logic                   hit_o,
    output logic                   multi_o,
    output logic [WB_LINE_W-1:0]   data_o
);

    logic [DEPTH-1:0] match;

    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = vld_i[i] && (entries_i[i].line_addr == line_addr_i);
        end
    end

    // Scanning downward leaves the lowest-index match as the final winner.
    always_comb begin
        data_o = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match[i]) begin
                data_o = entries_i[i].data;
            end
        end
    end

    assign hit_o   = |match;
    assign multi_o = |(match & (match - DEPTH'(1)));

endmodule

// File: rtl/l1d_wb_drain.sv
// rtl/l1d_wb_drain.sv - drains write-buffer head lines to memory one at a time and serves load probes
module l1d_wb_drain
    import l1d_wb_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int PADDR_W = WB_PADDR_W,
    parameter int LINE_W  = WB_LINE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               fifo_deq_vld_i,
    input  wb_entry_t          fifo_deq_payload_i,
    output logic               fifo_deq_rdy_o,
    input  wb_entry_t          fifo_payload_i [DEPTH],
    input  logic [DEPTH-1:0]   fifo_vld_i,
    l1d_wb_mem_if.master       mem,
    input  logic               lkup_vld_i,
    input  logic [PADDR_W-1:0] lkup_addr_i,
    output logic               lkup_hit_o,
    output logic               lkup_multi_o,
    output logic [LINE_W-1:0]  lkup_data_o,
    output logic               busy_o,
    output logic               err_o,
    output logic [15:0]        drain_cnt_o
);

    localparam int OFF_W = $clog2(LINE_W / 8);

    drain_state_e state_q, state_d;
    wb_entry_t    hold_q, hold_d;
    logic         flushed_q, flushed_d;
    logic         err_q, err_d;
    logic [15:0]  cnt_q, cnt_d;
    logic         pop;
    logic         req_vld;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        flushed_d = flushed_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        pop       = 1'b0;
        req_vld   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (fifo_deq_vld_i && !flush_i) begin
                    hold_d  = fifo_deq_payload_i;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                req_vld = 1'b1;
                if (mem.req_rdy) begin
                    state_d   = ST_RESP;
                    flushed_d = flush_i;
                end else if (flush_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (flush_i) begin
                    flushed_d = 1'b1;
                end
                if (mem.resp_vld) begin
                    // A flush on the ack cycle itself also cancels the pop.
                    pop       = !(flushed_q || flush_i);
                    state_d   = ST_IDLE;
                    flushed_d = 1'b0;
                    if (mem.resp_err) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                flushed_d = 1'b0;
            end
        endcase
        if (mem.resp_vld && state_q != ST_RESP) begin
            err_d = 1'b1;
        end
        if (pop && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            flushed_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            flushed_q <= flushed_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    assign mem.req_vld    = req_vld;
    assign mem.req_addr   = {hold_q.line_addr, {OFF_W{1'b0}}};
    assign mem.req_data   = hold_q.data;
    assign fifo_deq_rdy_o = pop;
    assign busy_o         = (state_q != ST_IDLE);
    assign err_o          = err_q;
    assign drain_cnt_o    = cnt_q;

    logic              cam_hit, cam_multi;
    logic [LINE_W-1:0] cam_data;
    logic              unused_offset_bits;

    assign unused_offset_bits = ^lkup_addr_i[OFF_W-1:0];

    l1d_wb_cam #(.DEPTH(DEPTH)) u_cam (
        .entries_i   (fifo_payload_i),
        .vld_i       (fifo_vld_i),
        .line_addr_i (lkup_addr_i[PADDR_W-1:OFF_W]),
        .hit_o       (cam_hit),
        .multi_o     (cam_multi),
        .data_o      (cam_data)
    );

    logic              lk_hit_q, lk_multi_q;
    logic [LINE_W-1:0] lk_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lk_hit_q   <= 1'b0;
            lk_multi_q <= 1'b0;
            lk_data_q  <= '0;
        end else begin
            lk_hit_q   <= lkup_vld_i && cam_hit;
            lk_multi_q <= lkup_vld_i && cam_multi;
            lk_data_q  <= (lkup_vld_i && cam_hit) ? cam_data : '0;
        end
    end

    assign lkup_hit_o   = lk_hit_q;
    assign lkup_multi_o = lk_multi_q;
    assign lkup_data_o  = lk_data_q;

endmodule

// File: tb/tb_l1d_wb_drain.sv
// tb/tb_l1d_wb_drain.sv - self-checking bench for l1d_wb_drain
module tb_l1d_wb_drain;
    import l1d_wb_pkg::*;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             flush_i;
    logic             fifo_deq_vld_i;
    wb_entry_t        fifo_deq_payload_i;
    logic             fifo_deq_rdy_o;
    wb_entry_t        pay_a [DEPTH];
    logic [DEPTH-1:0] vld_a;
    logic             lkup_vld_i;
    logic [55:0]      lkup_addr_i;
    logic             lkup_hit_o, lkup_multi_o;
    logic [511:0]     lkup_data_o;
    logic             busy_o, err_o;
    logic [15:0]      drain_cnt_o;

    l1d_wb_mem_if #(.PADDR_W(56), .LINE_W(512)) mem ();

    l1d_wb_drain #(.DEPTH(DEPTH), .PADDR_W(56), .LINE_W(512)) dut (
        .clk                (clk),
        .rst                (rst),
        .flush_i            (flush_i),
        .fifo_deq_vld_i     (fifo_deq_vld_i),
        .fifo_deq_payload_i (fifo_deq_payload_i),
        .fifo_deq_rdy_o     (fifo_deq_rdy_o),
        .fifo_payload_i     (pay_a),
        .fifo_vld_i         (vld_a),
        .mem                (mem.master),
        .lkup_vld_i         (lkup_vld_i),
        .lkup_addr_i        (lkup_addr_i),
        .lkup_hit_o         (lkup_hit_o),
        .lkup_multi_o       (lkup_multi_o),
        .lkup_data_o        (lkup_data_o),
        .busy_o             (busy_o),
        .err_o              (err_o),
        .drain_cnt_o        (drain_cnt_o)
    );

    typedef struct {
        logic [55:0]  addr;
        logic         vld;
        logic         hit;
        logic         multi;
        logic [511:0] data;
    } probe_vec_t;

    wb_entry_t fq[$];
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic wb_entry_t mk(input logic [55:0] addr, input logic [31:0] tag);
        wb_entry_t e;
        e.line_addr = addr[55:OFFSET_W];
        e.data      = {16{tag}};
        return e;
    endfunction

    function automatic logic [511:0] pat(input logic [31:0] tag);
        return {16{tag}};
    endfunction

    task automatic drive_fifo();
        for (int i = 0; i < DEPTH; i++) begin
            vld_a[i] = (i < fq.size());
            if (i < fq.size()) pay_a[i] = fq[i];
        end
        fifo_deq_vld_i     = (fq.size() > 0);
        fifo_deq_payload_i = (fq.size() > 0) ? fq[0] : '0;
    endtask

    task automatic tick();
        logic popped;
        #1;
        popped = fifo_deq_rdy_o;
        @(posedge clk);
        #1;
        if (popped && fq.size() > 0) void'(fq.pop_front());
        drive_fifo();
    endtask

    task automatic push(input wb_entry_t e);
        fq.push_back(e);
        drive_fifo();
    endtask

    task automatic clear_fifo();
        fq.delete();
        drive_fifo();
    endtask

    task automatic do_reset();
        rst = 1'b1; flush_i = 1'b0; lkup_vld_i = 1'b0; lkup_addr_i = '0;
        mem.req_rdy = 1'b0; mem.resp_vld = 1'b0; mem.resp_err = 1'b0;
        clear_fifo();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_vld"}, mem.req_vld, 0);
        chk({tag, "_deq_rdy"}, fifo_deq_rdy_o, 0);
        chk({tag, "_hit"}, lkup_hit_o, 0);
        chk({tag, "_multi"}, lkup_multi_o, 0);
        chk({tag, "_data"}, lkup_data_o, 0);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_cnt"}, drain_cnt_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
    endtask

    task automatic wait_req(input int max);
        int n = 0;
        while (!mem.req_vld && n < max) begin
            tick();
            n++;
        end
        chk("req_wait", mem.req_vld, 1);
    endtask

    // Fire the pending request, then ack it after ack_dly cycles.
    task automatic fire_and_ack(input logic err, input logic exp_pop, input int ack_dly);
        mem.req_rdy = 1'b1;
        #1;
        chk("prefire_deq_rdy", fifo_deq_rdy_o, 0);
        tick();
        mem.req_rdy = 1'b0;
        chk("resp_req_vld", mem.req_vld, 0);
        repeat (ack_dly) begin
            chk("resp_wait_deq_rdy", fifo_deq_rdy_o, 0);
            tick();
        end
        mem.resp_vld = 1'b1;
        mem.resp_err = err;
        #1;
        chk("ack_deq_rdy", fifo_deq_rdy_o, exp_pop);
        tick();
        mem.resp_vld = 1'b0;
        mem.resp_err = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        probe_vec_t pv[8];
        wb_entry_t  e;
        logic [55:0] a;
        logic [31:0] tg;
        logic exp_err;

        for (int i = 0; i < DEPTH; i++) pay_a[i] = '0;
        do_reset();
        chk_reset_vals("reset");

        // Single drain
        push(mk(56'h1000, 32'hA0A0_0001));
        tick();
        chk("single_req_vld", mem.req_vld, 1);
        chk("single_req_addr", mem.req_addr, 56'h1000);
        chk("single_req_data", mem.req_data, pat(32'hA0A0_0001));
        chk("single_busy", busy_o, 1);
        repeat (3) tick();
        chk("single_pre_deq", fifo_deq_rdy_o, 0);
        fire_and_ack(1'b0, 1'b1, 2);
        chk("single_cnt", drain_cnt_o, 1);
        chk("single_busy_after", busy_o, 0);
        chk("single_fifo_empty", fq.size(), 0);

        // Backpressure: request must hold steady with no pop
        push(mk(56'h2_0000_00BF, 32'hB0B0_0002));
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("bp_req_vld", mem.req_vld, 1);
            chk("bp_addr", mem.req_addr, 56'h2_0000_0080);
            chk("bp_data", mem.req_data, pat(32'hB0B0_0002));
            chk("bp_deq_rdy", fifo_deq_rdy_o, 0);
            tick();
        end
        fire_and_ack(1'b0, 1'b1, 0);
        chk("bp_cnt", drain_cnt_o, 2);

        // Flush in REQ without fire
        push(mk(56'h3000, 32'hC0C0_0003));
        tick();
        chk("flreq_req_vld", mem.req_vld, 1);
        flush_i = 1'b1;
        #1;
        chk("flreq_same_cycle_vld", mem.req_vld, 1);
        tick();
        clear_fifo();
        flush_i = 1'b0;
        chk("flreq_req_dropped", mem.req_vld, 0);
        chk("flreq_busy", busy_o, 0);
        tick();
        chk("flreq_stay_idle", busy_o, 0);
        chk("flreq_cnt", drain_cnt_o, 2);

        // Flush in RESP
        push(mk(56'h4000, 32'hD0D0_0004));
        tick();
        mem.req_rdy = 1'b1;
        tick();
        mem.req_rdy = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        clear_fifo();
        chk("flresp_busy", busy_o, 1);
        mem.resp_vld = 1'b1;
        #1;
        chk("flresp_no_pop", fifo_deq_rdy_o, 0);
        tick();
        mem.resp_vld = 1'b0;
        chk("flresp_cnt", drain_cnt_o, 2);
        chk("flresp_idle", busy_o, 0);
        chk("flresp_err", err_o, 0);

        // Flush coinciding with the fire
        push(mk(56'h5000, 32'hE0E0_0005));
        tick();
        mem.req_rdy = 1'b1;
        flush_i = 1'b1;
        tick();
        mem.req_rdy = 1'b0;
        flush_i = 1'b0;
        clear_fifo();
        chk("flfire_busy", busy_o, 1);
        chk("flfire_req_vld", mem.req_vld, 0);
        mem.resp_vld = 1'b1;
        #1;
        chk("flfire_no_pop", fifo_deq_rdy_o, 0);
        tick();
        mem.resp_vld = 1'b0;
        chk("flfire_cnt", drain_cnt_o, 2);

        // Flushed flag must not leak into the next transaction
        push(mk(56'h5040, 32'hE0E0_0006));
        tick();
        fire_and_ack(1'b0, 1'b1, 1);
        chk("postflush_cnt", drain_cnt_o, 3);

        // Error ack still pops; err is sticky
        push(mk(56'h6000, 32'hF0F0_0007));
        tick();
        fire_and_ack(1'b1, 1'b1, 1);
        chk("err_set", err_o, 1);
        chk("err_cnt", drain_cnt_o, 4);
        repeat (5) tick();
        chk("err_sticky", err_o, 1);

        // Spurious ack in IDLE
        do_reset();
        chk("spur_err_clr", err_o, 0);
        mem.resp_vld = 1'b1;
        #1;
        chk("spur_no_pop", fifo_deq_rdy_o, 0);
        tick();
        mem.resp_vld = 1'b0;
        chk("spur_err", err_o, 1);
        chk("spur_cnt", drain_cnt_o, 0);
        chk("spur_busy", busy_o, 0);

        // Reset mid-RESP with a live probe result
        do_reset();
        push(mk(56'h8000_0000, 32'h1234_5678));
        tick();
        mem.req_rdy = 1'b1;
        tick();
        mem.req_rdy = 1'b0;
        lkup_vld_i = 1'b1;
        lkup_addr_i = 56'h8000_0010;
        mem.resp_err = 1'b0;
        tick();
        chk("rstresp_hit", lkup_hit_o, 1);
        chk("rstresp_busy", busy_o, 1);
        rst = 1'b1;
        tick();
        chk_reset_vals("rst_mid_resp");
        rst = 1'b0;
        lkup_vld_i = 1'b0;

        // Probe table
        do_reset();
        fq.push_back(mk(56'h2040,    32'hC000_0000));
        fq.push_back(mk(56'h1000,    32'hC000_0001));
        fq.push_back(mk(56'h10_0000, 32'hC000_0002));
        fq.push_back(mk(56'h40,      32'hC000_0003));
        fq.push_back(mk(56'h80,      32'hC000_0004));
        fq.push_back(mk(56'hC0,      32'hC000_0005));
        fq.push_back(mk(56'h100,     32'hC000_0006));
        fq.push_back(mk(56'h40,      32'hC000_0007));
        fq.push_back(mk(56'h7700,    32'hC000_0008));
        drive_fifo();
        pay_a[9] = mk(56'h5000, 32'hC000_0009);
        pv[0] = '{56'h2040, 1'b1, 1'b1, 1'b0, pat(32'hC000_0000)};
        pv[1] = '{56'h3000, 1'b1, 1'b0, 1'b0, '0};
        pv[2] = '{56'h40,   1'b1, 1'b1, 1'b1, pat(32'hC000_0003)};
        pv[3] = '{56'h7F,   1'b1, 1'b1, 1'b1, pat(32'hC000_0003)};
        pv[4] = '{56'h2040, 1'b0, 1'b0, 1'b0, '0};
        pv[5] = '{56'h773F, 1'b1, 1'b1, 1'b0, pat(32'hC000_0008)};
        pv[6] = '{56'h5000, 1'b1, 1'b0, 1'b0, '0};
        pv[7] = '{56'h1000, 1'b1, 1'b1, 1'b0, pat(32'hC000_0001)};
        for (int i = 0; i < 8; i++) begin
            lkup_vld_i  = pv[i].vld;
            lkup_addr_i = pv[i].addr;
            tick();
            chk($sformatf("probe%0d_hit", i), lkup_hit_o, pv[i].hit);
            chk($sformatf("probe%0d_multi", i), lkup_multi_o, pv[i].multi);
            chk($sformatf("probe%0d_data", i), lkup_data_o, pv[i].data);
        end

        // Random probes against a linear-search reference
        for (int it = 0; it < 200; it++) begin
            int n;
            int hits;
            logic [511:0] first;
            logic ref_hit, ref_multi;
            fq.delete();
            n = $urandom_range(0, DEPTH);
            for (int k = 0; k < n; k++) begin
                a  = 56'hAB_0000 | (56'($urandom_range(0, 7)) << 6);
                fq.push_back(mk(a, $urandom));
            end
            drive_fifo();
            lkup_addr_i = 56'hAB_0000 | (56'($urandom_range(0, 9)) << 6) | 56'($urandom_range(0, 63));
            lkup_vld_i  = ($urandom_range(0, 3) != 0);
            hits = 0;
            first = '0;
            foreach (fq[k]) begin
                if ({fq[k].line_addr, 6'b0} == {lkup_addr_i[55:6], 6'b0}) begin
                    if (hits == 0) first = fq[k].data;
                    hits++;
                end
            end
            ref_hit   = lkup_vld_i && hits > 0;
            ref_multi = lkup_vld_i && hits > 1;
            tick();
            chk("rnd_probe_hit", lkup_hit_o, ref_hit);
            chk("rnd_probe_multi", lkup_multi_o, ref_multi);
            chk("rnd_probe_data", lkup_data_o, ref_hit ? first : 512'd0);
        end
        lkup_vld_i = 1'b0;

        // Random drain: requests must emerge in push order, one at a time
        do_reset();
        begin
            wb_entry_t exp_q[$];
            exp_err = 1'b0;
            for (int k = 0; k < 12; k++) begin
                a  = {$urandom, $urandom};
                tg = $urandom;
                e  = mk(a, tg);
                exp_q.push_back(e);
                fq.push_back(e);
            end
            drive_fifo();
            for (int k = 0; k < 12; k++) begin
                logic er;
                wait_req(20);
                chk("rnd_addr", mem.req_addr, {exp_q[k].line_addr, 6'b0});
                chk("rnd_data", mem.req_data, exp_q[k].data);
                repeat ($urandom_range(0, 4)) tick();
                er = ($urandom_range(0, 7) == 0);
                exp_err = exp_err | er;
                fire_and_ack(er, 1'b1, $urandom_range(0, 4));
                chk("rnd_cnt_step", drain_cnt_o, k + 1);
            end
            chk("rnd_cnt", drain_cnt_o, 12);
            chk("rnd_err", err_o, exp_err);
            chk("rnd_fifo_empty", fq.size(), 0);
            tick();
            chk("rnd_idle", busy_o, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
